// File: rtl/mips_irq_pkg.sv
// Shared definitions for the MIPS interrupt controller: register map, STATUS layout,
// FSM states, config request bundle and the vector helper.
package mips_irq_pkg;

  typedef enum logic [1:0] {
    CFG_MASK   = 2'd0,
    CFG_MODE   = 2'd1,
    CFG_PEND   = 2'd2,
    CFG_STATUS = 2'd3
  } cfg_addr_e;

  localparam int STAT_ID_LSB = 0;
  localparam int STAT_BUSY   = 8;
  localparam int STAT_REQ    = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  typedef struct packed {
    logic        we;
    cfg_addr_e   addr;
    logic [31:0] wd;
  } cfg_req_t;

  // Wraps modulo 2^32 on purpose; no overflow indication.
  function automatic logic [31:0] irq_vector(input logic [31:0] base, input logic [4:0] id,
                                             input int shift);
    return base + ({27'b0, id} << shift);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: index of the lowest set request bit, plus any-set flag.
module irq_prio_enc #(
  parameter int N = 6
) (
  input  logic [N-1:0] req,
  output logic         vld,
  output logic [4:0]   idx
);

  always_comb begin
    vld = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = 5'(i);
    end
  end

endmodule

// File: rtl/mips_irq_ctrl.sv
// Interrupt controller between raw IRQ lines and the core: synchronisers, mask/mode/pending
// registers, fixed-priority arbitration and a req/ack/eoi handshake producing a handler vector.
module mips_irq_ctrl
  import mips_irq_pkg::*;
#(
  parameter int          N_IRQ       = 6,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] VEC_BASE    = 32'h200,
  parameter int          VEC_SHIFT   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wd,
  output logic [31:0]      cfg_rd,
  input  logic             exl,
  output logic             irq_req,
  output logic [4:0]       irq_id,
  output logic [31:0]      irq_vec,
  input  logic             irq_ack,
  input  logic             eoi
);

  logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q, sync_d;
  logic [N_IRQ-1:0] s, s_q, pend_q, pend_d, mask_q, mask_d, mode_q, mode_d;
  logic [N_IRQ-1:0] elig, sel, w1c, clr;
  irq_state_e       state_q, state_d;
  logic [4:0]       id_q, id_d, enc_idx;
  logic             enc_vld, ack_take, cur_elig;
  cfg_req_t         cfg;

  assign cfg  = '{we: cfg_we, addr: cfg_addr_e'(cfg_addr), wd: cfg_wd};
  assign s    = sync_q[SYNC_STAGES-1];
  assign elig = pend_q & mask_q;

  if (N_IRQ < 32) begin : g_wd_hi
    logic unused_wd_hi;
    assign unused_wd_hi = ^cfg_wd[31:N_IRQ];
  end

  irq_prio_enc #(.N(N_IRQ)) u_enc (.req(elig), .vld(enc_vld), .idx(enc_idx));

  always_comb begin
    sync_d[0] = irq_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // One-hot of the latched channel; avoids indexing an N_IRQ vector with a 5-bit id.
  always_comb begin
    for (int i = 0; i < N_IRQ; i++) sel[i] = (id_q == 5'(i));
  end

  assign ack_take = (state_q == ST_REQ) && irq_ack;
  assign cur_elig = |(elig & sel);
  assign w1c      = (cfg.we && cfg.addr == CFG_PEND) ? cfg.wd[N_IRQ-1:0] : '0;
  assign clr      = w1c | (sel & {N_IRQ{ack_take}});

  // Edge channels: a new rising edge beats any clear in the same cycle. Level channels mirror s.
  always_comb begin
    pend_d = (mode_q & ((s & ~s_q) | (pend_q & ~clr))) | (~mode_q & s);
    mask_d = (cfg.we && cfg.addr == CFG_MASK) ? cfg.wd[N_IRQ-1:0] : mask_q;
    mode_d = (cfg.we && cfg.addr == CFG_MODE) ? cfg.wd[N_IRQ-1:0] : mode_q;
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_vld && !exl) begin
          id_d    = enc_idx;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (irq_ack)        state_d = ST_SERVICE;
        else if (!cur_elig) state_d = ST_IDLE;
      end
      ST_SERVICE: begin
        if (eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      s_q     <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      state_q <= ST_IDLE;
      id_q    <= '0;
    end else begin
      sync_q  <= sync_d;
      s_q     <= s;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  assign irq_req = (state_q == ST_REQ);
  assign irq_id  = id_q;
  assign irq_vec = irq_vector(VEC_BASE, id_q, VEC_SHIFT);

  always_comb begin
    cfg_rd = '0;
    case (cfg.addr)
      CFG_MASK: cfg_rd[N_IRQ-1:0] = mask_q;
      CFG_MODE: cfg_rd[N_IRQ-1:0] = mode_q;
      CFG_PEND: cfg_rd[N_IRQ-1:0] = pend_q;
      CFG_STATUS: begin
        cfg_rd[STAT_ID_LSB +: 5] = id_q;
        cfg_rd[STAT_BUSY]        = (state_q != ST_IDLE);
        cfg_rd[STAT_REQ]         = irq_req;
      end
      default: cfg_rd = '0;
    endcase
  end

endmodule

// File: tb/tb_mips_irq_ctrl.sv
// Bench for mips_irq_ctrl: directed scenarios plus a randomized run against a behavioural model.
module tb_mips_irq_ctrl;

  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  irq_in = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [31:0] cfg_wd = '0;
  logic [31:0] cfg_rd;
  logic        exl = 1'b0;
  logic        irq_req;
  logic [4:0]  irq_id;
  logic [31:0] irq_vec;
  logic        irq_ack = 1'b0;
  logic        eoi = 1'b0;

  int checks = 0;
  int failures = 0;

  mips_irq_ctrl #(.N_IRQ(6), .SYNC_STAGES(SS), .VEC_BASE(32'h200), .VEC_SHIFT(3)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wd(cfg_wd), .cfg_rd(cfg_rd), .exl(exl), .irq_req(irq_req), .irq_id(irq_id),
    .irq_vec(irq_vec), .irq_ack(irq_ack), .eoi(eoi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wd = d;
    tick();
    cfg_we = 1'b0; cfg_wd = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rd;
  endtask

  task automatic apply_reset();
    rst = 1'b0; irq_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wd = '0;
    exl = 1'b0; irq_ack = 1'b0; eoi = 1'b0;
    ticks(2);
    rst = 1'b1;
    tick();
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0;
    #2;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_reg%0d got=%h exp=0", a, d); end
    end
    checks++;
    if (irq_req !== 1'b0 || irq_id !== 5'd0 || irq_vec !== 32'h200) begin
      failures++; $display("FAIL reset_out req=%b id=%0d vec=%h exp 0/0/200", irq_req, irq_id, irq_vec);
    end
    apply_reset();
    wr(0, 32'h1);
    irq_in[0] = 1'b1;
    ticks(5);
    checks++;
    if (irq_req !== 1'b1) begin failures++; $display("FAIL reset_pre_req got=%b exp=1", irq_req); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (irq_req !== 1'b0) begin failures++; $display("FAIL reset_async_req got=%b exp=0", irq_req); end
    checks++;
    if (irq_vec !== 32'h200) begin failures++; $display("FAIL reset_mid_vec got=%h exp=200", irq_vec); end
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_mid_reg%0d got=%h exp=0", a, d); end
    end
    irq_in = '0;
    apply_reset();
  endtask

  task automatic test_edge_latency();
    logic [31:0] d;
    apply_reset();
    wr(0, 32'h1);
    wr(1, 32'h1);
    irq_in[0] = 1'b1;            // driven just after edge 0
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 1) irq_in[0] = 1'b0;
      checks++;
      if (irq_req !== (e == 4)) begin
        failures++; $display("FAIL edge_latency_e%0d got=%b exp=%b", e, irq_req, (e == 4));
      end
    end
    checks++;
    if (irq_vec !== 32'h200 || irq_id !== 5'd0) begin
      failures++; $display("FAIL edge_vec got=%h/%0d exp=200/0", irq_vec, irq_id);
    end
    pulse_ack();
    rd(2, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL edge_ack_pend got=%h exp=0", d); end
    rd(3, d);
    checks++;
    if (d !== 32'h100) begin failures++; $display("FAIL edge_service_status got=%h exp=100", d); end
    pulse_eoi();
    ticks(3);
    rd(3, d);
    checks++;
    if (d !== 32'h0 || irq_req !== 1'b0) begin
      failures++; $display("FAIL edge_after_eoi status=%h req=%b exp=0/0", d, irq_req);
    end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    apply_reset();
    wr(0, 32'h3F);
    irq_in = 6'b001010;
    ticks(5);
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 5'd1 || irq_vec !== 32'h208) begin
      failures++; $display("FAIL prio_first req=%b id=%0d vec=%h exp 1/1/208", irq_req, irq_id, irq_vec);
    end
    pulse_ack();
    wr(2, 32'h3F);               // W1C has no effect on level channels
    rd(2, d);
    checks++;
    if (d !== 32'h0A) begin failures++; $display("FAIL prio_level_w1c got=%h exp=0a", d); end
    irq_in[1] = 1'b0;
    ticks(5);
    pulse_eoi();
    tick();
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 5'd3 || irq_vec !== 32'h218) begin
      failures++; $display("FAIL prio_second req=%b id=%0d vec=%h exp 1/3/218", irq_req, irq_id, irq_vec);
    end
    irq_in = '0;
  endtask

  task automatic test_withdraw();
    logic [31:0] d;
    apply_reset();
    wr(0, 32'h3F);
    irq_in[2] = 1'b1;
    ticks(5);
    checks++;
    if (irq_req !== 1'b1 || irq_id !== 5'd2) begin
      failures++; $display("FAIL withdraw_req req=%b id=%0d exp 1/2", irq_req, irq_id);
    end
    irq_in[2] = 1'b0;
    ticks(4);
    rd(3, d);
    checks++;
    if (irq_req !== 1'b0 || d[8] !== 1'b0) begin
      failures++; $display("FAIL withdraw_idle req=%b busy=%b exp 0/0", irq_req, d[8]);
    end
  endtask

  task automatic test_blocking();
    logic [31:0] d;
    apply_reset();
    wr(0, 32'h1);
    wr(1, 32'h1);
    exl = 1'b1;
    irq_in[0] = 1'b1; tick(); irq_in[0] = 1'b0;
    ticks(6);
    rd(2, d);
    checks++;
    if (irq_req !== 1'b0 || d !== 32'h1) begin
      failures++; $display("FAIL block_exl req=%b pend=%h exp 0/1", irq_req, d);
    end
    exl = 1'b0;
    tick();
    checks++;
    if (irq_req !== 1'b1) begin failures++; $display("FAIL block_release got=%b exp=1", irq_req); end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    apply_reset();
    wr(1, 32'h10);
    irq_in[4] = 1'b1; tick(); irq_in[4] = 1'b0;
    ticks(4);
    rd(2, d);
    checks++;
    if (d !== 32'h10) begin failures++; $display("FAIL setwins_pend got=%h exp=10", d); end
    wr(2, 32'h10);
    rd(2, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL setwins_w1c got=%h exp=0", d); end
    irq_in[4] = 1'b1;
    ticks(2);
    cfg_we = 1'b1; cfg_addr = 2; cfg_wd = 32'h10;
    tick();
    cfg_we = 1'b0;
    rd(2, d);
    checks++;
    if (d !== 32'h10) begin failures++; $display("FAIL setwins_collide got=%h exp=10", d); end
    irq_in = '0;
  endtask

  // Randomized traffic against a cycle-level model of the programmer-visible rules.
  task automatic test_random();
    logic [5:0]  dly [SS];
    logic [5:0]  m_sprev, m_pend, m_mask, m_mode, s, e, np;
    logic [31:0] exp_rd;
    int          m_st, m_id, low, b;
    logic        set, clr_b;
    apply_reset();
    for (int i = 0; i < SS; i++) dly[i] = '0;
    m_sprev = '0; m_pend = '0; m_mask = '0; m_mode = '0; m_st = 0; m_id = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 4) == 0) begin b = $urandom_range(0, 5); irq_in[b] = ~irq_in[b]; end
      exl      = ($urandom_range(0, 9) == 0);
      irq_ack  = ($urandom_range(0, 2) == 0);
      eoi      = ($urandom_range(0, 3) == 0);
      cfg_we   = ($urandom_range(0, 11) == 0);
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_wd   = $urandom;
      #1;
      case (cfg_addr)
        2'd0: exp_rd = {26'b0, m_mask};
        2'd1: exp_rd = {26'b0, m_mode};
        2'd2: exp_rd = {26'b0, m_pend};
        default: exp_rd = 32'(m_id) | ((m_st != 0) ? 32'h100 : 32'h0) | ((m_st == 1) ? 32'h200 : 32'h0);
      endcase
      checks++;
      if (irq_req !== (m_st == 1) || irq_id !== 5'(m_id) || irq_vec !== 32'h200 + 32'(m_id) * 8) begin
        failures++;
        $display("FAIL rand_out cyc=%0d req=%b id=%0d vec=%h exp %b/%0d/%h", c, irq_req, irq_id,
                 irq_vec, (m_st == 1), m_id, 32'h200 + 32'(m_id) * 8);
      end
      checks++;
      if (cfg_rd !== exp_rd) begin
        failures++; $display("FAIL rand_rd cyc=%0d addr=%0d got=%h exp=%h", c, cfg_addr, cfg_rd, exp_rd);
      end
      @(posedge clk);
      s = dly[SS-1];
      e = m_pend & m_mask;
      low = -1;
      for (int i = 5; i >= 0; i--) if (e[i]) low = i;
      for (int ch = 0; ch < 6; ch++) begin
        if (m_mode[ch]) begin
          set   = s[ch] && !m_sprev[ch];
          clr_b = (cfg_we && cfg_addr == 2 && cfg_wd[ch]) || (m_st == 1 && irq_ack && m_id == ch);
          np[ch] = set || (m_pend[ch] && !clr_b);
        end else begin
          np[ch] = s[ch];
        end
      end
      case (m_st)
        0: if (low >= 0 && !exl) begin m_id = low; m_st = 1; end
        1: if (irq_ack) m_st = 2; else if (!e[m_id]) m_st = 0;
        default: if (eoi) m_st = 0;
      endcase
      if (cfg_we && cfg_addr == 0) m_mask = cfg_wd[5:0];
      if (cfg_we && cfg_addr == 1) m_mode = cfg_wd[5:0];
      m_pend  = np;
      m_sprev = s;
      for (int i = SS - 1; i > 0; i--) dly[i] = dly[i-1];
      dly[0] = irq_in;
      #1;
    end
    cfg_we = 1'b0; irq_ack = 1'b0; eoi = 1'b0; exl = 1'b0; irq_in = '0;
  endtask

  initial begin
    test_reset();
    test_edge_latency();
    test_priority();
    test_withdraw();
    test_blocking();
    test_set_wins();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
